// File: rtl/counter_with_history.sv
// Up/down counter with hold mode and a DEPTH-entry circular snapshot history.
// Defining COUNTER_HIST_CLEAR_EN adds the hist_clr input to empty the history.
module counter_with_history #(
  parameter int unsigned  WIDTH    = 4,
  parameter int unsigned  DEPTH    = 4,
  parameter bit           SATURATE = 1'b0,
  localparam int unsigned IW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             hold,
  input  logic             save,
  input  logic             restore,
  input  logic [IW-1:0]    rd_idx,
`ifdef COUNTER_HIST_CLEAR_EN
  input  logic             hist_clr,
`endif
  output logic [WIDTH-1:0] y,
  output logic             wrap,
  output logic             err,
  output logic [IW:0]      valid_cnt,
  output logic             full
);

  localparam logic [IW:0] DepthCnt = (IW+1)'(DEPTH);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic [IW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [IW:0]      valid_cnt_q, valid_cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             restore_ok;
  logic             mem_we;
  logic             hist_clear;
  logic [IW-1:0]    rd_addr;

`ifdef COUNTER_HIST_CLEAR_EN
  assign hist_clear = hist_clr;
`else
  assign hist_clear = 1'b0;
`endif

  // Index 0 is the most recent save, which sits one slot behind the write pointer.
  assign restore_ok = restore && ({1'b0, rd_idx} < valid_cnt_q);
  assign rd_addr    = wr_ptr_q - IW'(1) - rd_idx;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (restore_ok) begin
      count_d = mem_q[rd_addr];
    end else if (!hold && en) begin
      if (up) begin
        if (&count_q) begin
          if (!SATURATE) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          if (!SATURATE) begin
            count_d = '1;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    err_d = restore && !restore_ok;
    y_d   = hold ? '0 : count_d;
  end

  // A clear wins over a same-cycle save; the restore above already used pre-clear state.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    valid_cnt_d = valid_cnt_q;
    mem_we      = 1'b0;
    if (hist_clear) begin
      wr_ptr_d    = '0;
      valid_cnt_d = '0;
    end else if (save) begin
      mem_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + IW'(1);
      if (valid_cnt_q != DepthCnt) begin
        valid_cnt_d = valid_cnt_q + (IW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      y_q         <= '0;
      wrap_q      <= 1'b0;
      err_q       <= 1'b0;
      wr_ptr_q    <= '0;
      valid_cnt_q <= '0;
    end else begin
      count_q     <= count_d;
      y_q         <= y_d;
      wrap_q      <= wrap_d;
      err_q       <= err_d;
      wr_ptr_q    <= wr_ptr_d;
      valid_cnt_q <= valid_cnt_d;
    end
  end

  // History storage needs no reset: entries beyond valid_cnt are never read.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= count_q;
    end
  end

  assign y         = y_q;
  assign wrap      = wrap_q;
  assign err       = err_q;
  assign valid_cnt = valid_cnt_q;
  assign full      = (valid_cnt_q == DepthCnt);

endmodule
